// File: rtl/wishbone_if.sv
// Wishbone bus bundle shared by the UART master and the peripheral slaves.
// The master drives cycle/strobe/write_enable/address/data_in; the slave returns data_out and ack.
interface wishbone_if;
    logic        cycle;
    logic        strobe;
    logic        write_enable;
    logic [31:0] address;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        ack;

    modport master (
        output cycle, strobe, write_enable, address, data_in,
        input  data_out, ack
    );

    modport slave (
        input  cycle, strobe, write_enable, address, data_in,
        output data_out, ack
    );
endinterface

// File: rtl/uart_wb_master.sv
// UART command-frame decoder issuing one Wishbone transaction per frame and returning a status/data response.
// Bus outputs are registered; rx has no backpressure (bytes during EXEC/RESP are dropped with an o_overrun pulse).
// Optional ack timeout with 0xEE response is compiled in by `UART_WB_TIMEOUT_EN`.
module uart_wb_master #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    wishbone_if.master  wishbone,
    input  logic        i_rx_valid,
    input  logic [7:0]  i_rx_data,
    output logic        o_tx_valid,
    output logic [7:0]  o_tx_data,
    input  logic        i_tx_ready,
    output logic        o_overrun
);
    localparam logic [7:0] CMD_READ  = 8'h01;
    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] RSP_OK    = 8'hA5;
    localparam logic [7:0] RSP_TMO   = 8'hEE;
    localparam logic [7:0] RSP_BAD   = 8'hE1;

    typedef enum logic [2:0] {IDLE, ADDR, WDATA, EXEC, RESP} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  byte_cnt;
    logic        is_write;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [39:0] resp_buf;
    logic [2:0]  resp_left;
    logic        overrun_q;
    logic        bus_act;
    logic        bus_we;
    logic        cmd_ok;
    logic        tx_fire;
    logic        timeout;

    assign cmd_ok  = (i_rx_data == CMD_READ) || (i_rx_data == CMD_WRITE);
    assign tx_fire = (state == RESP) && i_tx_ready;

`ifdef UART_WB_TIMEOUT_EN
    localparam int TW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    logic [TW-1:0] tmo_cnt;

    // Counter sits at zero outside EXEC, so it restarts on every entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            tmo_cnt <= '0;
        else if (state != EXEC)
            tmo_cnt <= '0;
        else
            tmo_cnt <= tmo_cnt + 1'b1;
    end

    assign timeout = (state == EXEC) && (tmo_cnt == TW'(ACK_TIMEOUT - 1));
`else
    logic [31:0] unused_ack_timeout;
    assign unused_ack_timeout = ACK_TIMEOUT;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_rx_valid) state_nxt = cmd_ok ? ADDR : RESP;
            ADDR:    if (i_rx_valid && byte_cnt == 2'd3) state_nxt = is_write ? WDATA : EXEC;
            WDATA:   if (i_rx_valid && byte_cnt == 2'd3) state_nxt = EXEC;
            EXEC:    if (wishbone.ack || timeout) state_nxt = RESP;
            RESP:    if (tx_fire && resp_left == 3'd1) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        wishbone.cycle        = bus_act;
        wishbone.strobe       = bus_act;
        wishbone.write_enable = bus_we;
        wishbone.address      = addr_q;
        wishbone.data_in      = wdata_q;
        o_tx_valid            = (state == RESP);
        o_tx_data             = (state == RESP) ? resp_buf[7:0] : 8'h00;
        o_overrun             = overrun_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            byte_cnt  <= 2'd0;
            is_write  <= 1'b0;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            resp_buf  <= 40'h0;
            resp_left <= 3'd0;
            overrun_q <= 1'b0;
            bus_act   <= 1'b0;
            bus_we    <= 1'b0;
        end else begin
            overrun_q <= i_rx_valid && (state == EXEC || state == RESP);
            // Bus strobes follow the next state so they are flops, not decodes.
            bus_act   <= (state_nxt == EXEC);
            bus_we    <= (state_nxt == EXEC) && is_write;
            case (state)
                IDLE: if (i_rx_valid) begin
                    is_write  <= (i_rx_data == CMD_WRITE);
                    byte_cnt  <= 2'd0;
                    resp_buf  <= {32'h0, RSP_BAD};
                    resp_left <= 3'd1;
                end
                ADDR: if (i_rx_valid) begin
                    addr_q   <= {i_rx_data, addr_q[31:8]};
                    byte_cnt <= byte_cnt + 2'd1;
                end
                WDATA: if (i_rx_valid) begin
                    wdata_q  <= {i_rx_data, wdata_q[31:8]};
                    byte_cnt <= byte_cnt + 2'd1;
                end
                EXEC: if (wishbone.ack) begin
                    resp_buf  <= is_write ? {32'h0, RSP_OK} : {wishbone.data_out, RSP_OK};
                    resp_left <= is_write ? 3'd1 : 3'd5;
                end else if (timeout) begin
                    resp_buf  <= {32'h0, RSP_TMO};
                    resp_left <= 3'd1;
                end
                RESP: if (tx_fire) begin
                    resp_buf  <= {8'h00, resp_buf[39:8]};
                    resp_left <= resp_left - 3'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/uart_wb_master.md
# uart_wb_master

Byte-stream command decoder and Wishbone initiator: it turns command frames received over the UART into single Wishbone master transactions and returns a status/data response over the UART. It sits between a `uart_rx`/`uart_tx` pair and the system Wishbone bus, driving the same `wishbone_if` used by `uart_wishbone` and other peripheral slaves, from the master side. It gives the host debug/load access to the whole address map.

## Interface
Parameters:
- `ACK_TIMEOUT`, 255: max cycles to wait for `ack` after `cycle`/`strobe` assert; used only with `UART_WB_TIMEOUT_EN`.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `wishbone`  `wishbone_if.master`  -  drives `cycle`, `strobe`, `write_enable`, `address[31:0]`, `data_in[31:0]` (write data); samples `data_out[31:0]` (read data) and `ack`.
- `i_rx_valid`  in  1  one-cycle pulse: received byte on `i_rx_data`.
- `i_rx_data`  in  8  received byte.
- `o_tx_valid`  out  1  response byte valid; held until accepted.
- `o_tx_data`  out  8  response byte; stable while `o_tx_valid`.
- `i_tx_ready`  in  1  transmitter ready; byte accepted when `o_tx_valid && i_tx_ready`.
- `o_overrun`  out  1  one-cycle pulse: an rx byte arrived while busy and was dropped.

## Operation
- Frame format: cmd byte, 4 address bytes (LSB first), then 4 write-data bytes (LSB first) for writes only.
  - Cmd `0x01`: read.
  - Cmd `0x02`: write.
  - Any other cmd: respond `0xE1` and do not touch the bus.
- Responses:
  - Write: one byte, `0xA5` ok or `0xEE` timeout.
  - Read: `0xA5` followed by 4 data bytes, LSB first, or `0xEE` alone on timeout.
- States:
  - `IDLE`: wait for a cmd byte. Valid cmd → `ADDR`; unknown cmd → `RESP`.
  - `ADDR`: collect 4 bytes. Byte count 3 → `EXEC` for a read, `WDATA` for a write.
  - `WDATA`: collect 4 bytes → `EXEC`.
  - `EXEC`: drive `cycle = strobe = 1` with `address`, `write_enable`, and `data_in` stable. On `ack`: deassert all, latch `data_out` on reads → `RESP`.
  - `RESP`: shift out response bytes → `IDLE` after the last byte is accepted.
- Byte counter is 2 bits and wraps. Address and data shift registers are 32 bits.
- Bytes arriving in `EXEC` or `RESP` are dropped and pulse `o_overrun`. Bytes in `IDLE`/`ADDR`/`WDATA` are always accepted; there is no backpressure.
- `ack` seen outside `EXEC` is ignored.

## Timing
- Reset values: all outputs are 0 (`cycle`, `strobe`, `write_enable`, `address`, `data_in`, `o_tx_valid`, `o_tx_data`, `o_overrun`); state is `IDLE`; counters are 0.
- `cycle`/`strobe` assert on the cycle after the last frame byte is captured.
- Bus outputs are registered. If `ack` is high on edge N, `cycle`/`strobe` are low after edge N. This gives 2 bus cycles per transfer against `uart_wishbone`.
- `o_tx_valid` asserts on the cycle after `ack` (or after the unknown cmd is captured).
- After a handshake, the next byte is presented on the following cycle. `o_tx_valid` drops after the final byte.
- Reset mid-transaction aborts immediately: bus released, frame discarded.
- Timeout counter clears on entry to `EXEC`. At count `ACK_TIMEOUT - 1` without `ack`: deassert, respond `0xEE`. If `ack` and timeout occur on the same cycle, `ack` wins.

## Configuration
- `UART_WB_TIMEOUT_EN` defined: ack timeout counter and `0xEE` path are compiled in.
- `UART_WB_TIMEOUT_EN` undefined: `EXEC` waits for `ack` indefinitely, `0xEE` is never sent, and the `ACK_TIMEOUT` parameter is unused.

## Test plan
- Write: rx `02 0C 00 00 10 78 56 34 12` → one bus write, `address = 0x1000000C`, `data_in = 0x12345678`, `write_enable = 1`; tx `A5`.
- Read: rx `01 08 00 00 10`, slave returns `0x000000C3` → tx `A5 C3 00 00 00`; `write_enable = 0` throughout.
- Unknown cmd: rx `7F` → tx `E1`, no `cycle` assertion, next frame decodes normally.
- Timeout (macro on, `ACK_TIMEOUT = 16`), slave never acks: rx `01 00 00 00 20` → `cycle` high for exactly 16 cycles, then tx `EE`.
- Overrun: rx byte `55` during `RESP` with `i_tx_ready` held low → `o_overrun` pulses once, response unchanged.
- Reset: assert `reset_n = 0` during `EXEC` → `cycle`/`strobe`/`o_tx_valid` low immediately; a following write frame works normally.
